addsub8_reg: RTL and testbench

Registered 8-bit two's-complement adder/subtractor with signed-overflow detection. It computes a + b when m = 0 and a − b when m = 1, using a conditional operand inverter and a ripple-carry adder. Results are registered on the system clock. The block serves as the arithmetic datapath slice for small ALU and accumulator blocks, and it exposes the conditionally-inverted operand for debug and verification.

---
 rtl/addsub8_reg_pkg.sv | 14 +
 rtl/addsub8_reg_if.sv | 32 +++
 rtl/addsub8_reg_full_adder.sv | 21 ++
 rtl/addsub8_reg_inv8.sv | 18 +
 rtl/addsub8_reg.sv | 77 +++++++
 tb/tb_addsub8_reg.sv | 137 +++++++++++++
 6 files changed

// File: rtl/addsub8_reg_pkg.sv
// rtl/addsub8_reg_pkg.sv - shared constants for the addsub8_reg datapath slice
//
// Purpose: width and mode encodings used by the adder/subtractor, its
//          sub-modules, its bus interface and its testbench.
// Ports:   none (package).
package addsub8_reg_pkg;

  localparam int WIDTH = 8;

  // Mode select on m: add passes b through, subtract inverts b and injects carry-in.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub8_reg_if.sv
// rtl/addsub8_reg_if.sv - operand/result bundle for addsub8_reg
//
// Purpose: groups the operation request (in_valid, a, b, m) and the
//          registered result (s, ovf, cout, e, out_valid) of addsub8_reg.
// Modports:
//   master - issues operations, observes results (testbench / parent ALU)
//   slave  - the addsub8_reg datapath
interface addsub8_reg_if;
  import addsub8_reg_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;

  logic [WIDTH-1:0] s;
  logic             ovf;
  logic             cout;
  logic [WIDTH-1:0] e;
  logic             out_valid;

  modport master (
    output in_valid, a, b, m,
    input  s, ovf, cout, e, out_valid
  );

  modport slave (
    input  in_valid, a, b, m,
    output s, ovf, cout, e, out_valid
  );

endinterface

// File: rtl/addsub8_reg_full_adder.sv
// rtl/addsub8_reg_full_adder.sv - one-bit full adder cell of the ripple chain
//
// Purpose: sum and majority carry for one bit position.
// Ports:
//   a    in  1  operand A bit
//   b    in  1  conditioned operand B bit
//   cin  in  1  carry in
//   s    out 1  sum bit
//   cout out 1  carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub8_reg_inv8.sv
// rtl/addsub8_reg_inv8.sv - conditional 8-bit operand inverter
//
// Purpose: e = b ^ {8{m}}; passes b for add, ones-complements it for subtract.
// Ports:
//   b  in  8  operand B
//   m  in  1  mode (0 add, 1 subtract)
//   e  out 8  conditioned operand
module inv8
  import addsub8_reg_pkg::*;
(
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] e
);

  assign e = b ^ {WIDTH{m}};

endmodule

// File: rtl/addsub8_reg.sv
// rtl/addsub8_reg.sv - registered 8-bit two's-complement adder/subtractor
//
// Purpose: s = a + b (m = 0) or a - b (m = 1), mod 256, with signed overflow
//          and carry-out; all results registered with one cycle of latency.
// Ports:
//   clk  in  1  system clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of addsub8_reg_if:
//        in_valid/a/b/m in, s/ovf/cout/e/out_valid out (all registered)
module addsub8_reg
  import addsub8_reg_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  addsub8_reg_if.slave  bus
);

  logic [WIDTH-1:0] e_comb;
  logic [WIDTH-1:0] s_comb;
  logic [WIDTH:0]   c;
  logic             ovf_comb;
  logic             cout_comb;

  logic [WIDTH-1:0] s_q;
  logic             ovf_q;
  logic             cout_q;
  logic [WIDTH-1:0] e_q;
  logic             out_valid_q;

  inv8 u_inv8 (
    .b (bus.b),
    .m (bus.m),
    .e (e_comb)
  );

  // Subtract is a + ~b + 1: the +1 enters as carry-in to bit 0.
  assign c[0] = bus.m;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (bus.a[i]),
      .b    (e_comb[i]),
      .cin  (c[i]),
      .s    (s_comb[i]),
      .cout (c[i+1])
    );
  end

  // Signed overflow occurs exactly when carry into and out of the sign bit differ.
  assign ovf_comb  = c[WIDTH-1] ^ c[WIDTH];
  assign cout_comb = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q    <= s_comb;
        ovf_q  <= ovf_comb;
        cout_q <= cout_comb;
        e_q    <= e_comb;
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.ovf       = ovf_q;
  assign bus.cout      = cout_q;
  assign bus.e         = e_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_addsub8_reg.sv
// tb/tb_addsub8_reg.sv - self-checking bench for addsub8_reg
module tb_addsub8_reg;
  import addsub8_reg_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  addsub8_reg_if bus ();

  addsub8_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one request before the edge, then sample just after it.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.m        = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] xs, input logic xovf,
                           input logic xcout, input logic [7:0] xe, input logic xvalid);
    check({tag, "_s"},    {8'h00, bus.s},        {8'h00, xs});
    check({tag, "_ovf"},  {15'h0, bus.ovf},      {15'h0, xovf});
    check({tag, "_cout"}, {15'h0, bus.cout},     {15'h0, xcout});
    check({tag, "_e"},    {8'h00, bus.e},        {8'h00, xe});
    check({tag, "_vld"},  {15'h0, bus.out_valid}, {15'h0, xvalid});
  endtask

  // Independent reference: arithmetic difference/sum, unsigned compare for
  // carry, sign rule for overflow on the effective addend.
  task automatic sweep_op(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] xs, xe;
    logic       xc, xo;
    xs = (m == MODE_SUB) ? (a - b) : (a + b);
    xe = (m == MODE_SUB) ? ~b : b;
    xc = (m == MODE_SUB) ? (a >= b) : ((int'(a) + int'(b)) > 255);
    xo = (a[7] == xe[7]) && (xs[7] != a[7]);
    step(1'b1, a, b, m);
    if (bus.s !== xs || bus.ovf !== xo || bus.cout !== xc || bus.e !== xe || bus.out_valid !== 1'b1)
      $display("  at a=%h b=%h m=%b", a, b, m);
    check("sweep_s",    {8'h00, bus.s},         {8'h00, xs});
    check("sweep_ovf",  {15'h0, bus.ovf},       {15'h0, xo});
    check("sweep_cout", {15'h0, bus.cout},      {15'h0, xc});
    check("sweep_e",    {8'h00, bus.e},         {8'h00, xe});
    check("sweep_vld",  {15'h0, bus.out_valid}, 16'h0001);
  endtask

  logic [7:0] extra_b [5];

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.m        = 1'($urandom);

    // Reset held two edges while valid random ops are offered.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      check_out("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    end

    // First edge after release captures; result visible right after it.
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hFF, 8'h01, MODE_ADD);
    check_out("add_ff_01", 8'h00, 1'b0, 1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h7F, 8'h01, MODE_ADD);
    check_out("add_7f_01", 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
    step(1'b1, 8'h01, 8'hFF, MODE_ADD);
    check_out("add_01_ff", 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h80, 8'h01, MODE_SUB);
    check_out("sub_80_01", 8'h7F, 1'b1, 1'b1, 8'hFE, 1'b1);
    step(1'b1, 8'h6C, 8'hCA, MODE_SUB);
    check_out("sub_6c_ca", 8'hA2, 1'b1, 1'b0, 8'h35, 1'b1);
    step(1'b1, 8'h55, 8'hAA, MODE_ADD);
    check_out("add_55_aa", 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b1);

    // Idle cycles with wiggling operands must not disturb held results.
    step(1'b0, 8'h12, 8'h34, MODE_SUB);
    check_out("hold0", 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b0);
    step(1'b0, 8'hFE, 8'h99, MODE_ADD);
    check_out("hold1", 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b0);
    step(1'b0, 8'h80, 8'h80, MODE_SUB);
    check_out("hold2", 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b0);

    // Reset coincident with a valid op discards it.
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h7F, 8'h01, MODE_ADD);
    check_out("mid_rst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check("mid_rst_s_ne_80", {15'h0, bus.s != 8'h80}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back sweep: every a, both modes, a strided set of b plus sign-boundary b.
    extra_b[0] = 8'h01;
    extra_b[1] = 8'h7F;
    extra_b[2] = 8'h80;
    extra_b[3] = 8'h81;
    extra_b[4] = 8'hFE;
    for (int mi = 0; mi < 2; mi++) begin
      for (int ai = 0; ai < 256; ai++) begin
        for (int bi = 0; bi < 256; bi += 5)
          sweep_op(8'(ai), 8'(bi), 1'(mi));
        for (int xi = 0; xi < 5; xi++)
          sweep_op(8'(ai), extra_b[xi], 1'(mi));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
